// File: rtl/kv_srl_fifo_stream_if.sv
// rtl/kv_srl_fifo_stream_if.sv - FIFO read port plus output stream bundle for the SRL FIFO read adapter
interface kv_srl_fifo_stream_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_q;
  logic             fifo_rd_en;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
  logic [1:0]       level;

  // Adapter side: consumes the FIFO read port and drives the stream.
  modport master (
    input  fifo_empty,
    input  fifo_q,
    output fifo_rd_en,
    output m_valid,
    output m_data,
    input  m_ready,
    output level
  );

  // Environment side: FIFO plus downstream consumer.
  modport slave (
    output fifo_empty,
    output fifo_q,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data,
    output m_ready,
    input  level
  );
endinterface

// File: rtl/kv_srl_fifo_stream.sv
// rtl/kv_srl_fifo_stream.sv - 3-entry prefetch adapter turning the FIFO read port into a valid/ready stream
module kv_srl_fifo_stream #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  kv_srl_fifo_stream_if.master bus
);

  logic [1:0]       occ_q;
  logic             pend_q;
  logic [1:0]       head_q;
  logic [1:0]       tail_q;
  logic [WIDTH-1:0] buf_q [3];

  logic [2:0] outstanding;
  logic       rd_en;
  logic       pop;
  logic [1:0] occ_d;

  // Pointers cycle 0 -> 1 -> 2 -> 0 over the three buffer slots.
  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Read issue and pop decode; the read counts the in-flight word so the buffer never overflows,
  // and it never looks at m_ready.
  always_comb begin
    outstanding = {1'b0, occ_q} + {2'b00, pend_q};
    rd_en       = !rst && !bus.fifo_empty && (outstanding <= 3'd2);
    pop         = (occ_q != 2'd0) && bus.m_ready;
    occ_d       = occ_q + {1'b0, pend_q} - {1'b0, pop};
  end

  // Control state: occupancy, in-flight flag and ring pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= 2'd0;
      pend_q <= 1'b0;
      head_q <= 2'd0;
      tail_q <= 2'd0;
    end else begin
      occ_q  <= occ_d;
      pend_q <= rd_en;
      if (pend_q) begin
        tail_q <= wrap_inc(tail_q);
      end
      if (pop) begin
        head_q <= wrap_inc(head_q);
      end
    end
  end

  // Capture the word returned for last cycle's read; contents need no reset.
  always_ff @(posedge clk) begin
    if (!rst && pend_q) begin
      buf_q[tail_q] <= bus.fifo_q;
    end
  end

  // Outputs come from registered state only.
  always_comb begin
    bus.fifo_rd_en = rd_en;
    bus.m_valid    = (occ_q != 2'd0);
    bus.m_data     = buf_q[head_q];
    bus.level      = occ_q;
  end

endmodule

// File: tb/tb_kv_srl_fifo_stream.sv
// tb/tb_kv_srl_fifo_stream.sv - scoreboard bench for the SRL FIFO stream adapter
module tb_kv_srl_fifo_stream;

  logic clk = 1'b0;
  logic rst;
  logic fifo_rst;
  logic wr_en;
  logic [7:0] wr_data;
  logic err_und;
  logic [7:0] fmem[$];
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  kv_srl_fifo_stream_if #(.WIDTH(8)) bus ();

  kv_srl_fifo_stream #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: registered q on rd_en, registered empty, sticky underflow flag.
  always @(posedge clk) begin
    if (fifo_rst) begin
      fmem.delete();
      bus.fifo_empty <= 1'b1;
      err_und <= 1'b0;
    end else begin
      if (bus.fifo_rd_en) begin
        if (fmem.size() == 0) err_und <= 1'b1;
        else bus.fifo_q <= fmem.pop_front();
      end
      if (wr_en) fmem.push_back(wr_data);
      bus.fifo_empty <= (fmem.size() == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every accepted word is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", bus.m_data);
      end else begin
        check("stream_data", {24'd0, bus.m_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0 && bus.level == 2'd0) break;
      tick();
    end
    check(name, exp_q.size(), 0);
  endtask

  int n_rd;
  int n_valid;

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    fifo_rst = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    bus.m_ready = 1'b0;
    tick();
    tick();
    fifo_rst = 1'b0;

    // Reset with FIFO preloaded: adapter stays silent.
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rd_en", bus.fifo_rd_en, 0);
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_level", bus.level, 0);
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    check("first_rd_after_rst", bus.fifo_rd_en, 1);
    bus.m_ready = 1'b1;
    wait_drain("drain_preload", 20);

    // Single word: exactly one read, one valid cycle.
    n_rd = 0;
    n_valid = 0;
    fork
      write_word(8'hA5);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (bus.fifo_rd_en) n_rd++;
        if (bus.m_valid) n_valid++;
      end
    join
    check("single_rd_pulses", n_rd, 1);
    check("single_valid_cycles", n_valid, 1);
    check("single_err_und", err_und, 0);

    // Streaming 30 words back to back: no bubbles.
    n_valid = 0;
    fork
      for (int i = 0; i < 30; i++) write_word(i[7:0]);
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (bus.m_valid) break;
        end
        while (bus.m_valid && n_valid < 40) begin
          n_valid++;
          @(negedge clk);
        end
      end
    join
    check("stream_consecutive", n_valid, 30);
    wait_drain("drain_stream", 20);

    // Backpressure: buffer fills to 3, reads stop, FIFO keeps 7.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 10; i++) write_word(8'h80 + i[7:0]);
    for (int i = 0; i < 8; i++) tick();
    @(negedge clk);
    check("bp_level", bus.level, 3);
    check("bp_rd_en", bus.fifo_rd_en, 0);
    check("bp_fifo_count", fmem.size(), 7);
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0) break;
      bus.m_ready = ~bus.m_ready;
      tick();
    end
    bus.m_ready = 1'b1;
    wait_drain("drain_toggle", 10);
    check("bp_err_und", err_und, 0);

    // Simultaneous capture and pop at level 2.
    bus.m_ready = 1'b0;
    write_word(8'h61);
    write_word(8'h62);
    for (int i = 0; i < 4; i++) tick();
    write_word(8'h63);
    @(negedge clk);
    check("sim_rd_en", bus.fifo_rd_en, 1);
    tick();
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("sim_level_before", bus.level, 2);
    check("sim_no_second_rd", bus.fifo_rd_en, 0);
    tick();
    bus.m_ready = 1'b0;
    @(negedge clk);
    check("sim_level_after", bus.level, 2);
    bus.m_ready = 1'b1;
    wait_drain("drain_sim", 20);
    check("sim_err_und", err_und, 0);

    // Reset with level 2 and a read in flight.
    bus.m_ready = 1'b0;
    write_word(8'h71);
    write_word(8'h72);
    for (int i = 0; i < 4; i++) tick();
    write_word(8'h73);
    tick();
    @(negedge clk);
    check("mid_level_pre", bus.level, 2);
    tick();
    rst = 1'b1;
    fifo_rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_rd_en", bus.fifo_rd_en, 0);
    tick();
    rst = 1'b0;
    fifo_rst = 1'b0;
    @(negedge clk);
    check("mid_m_valid", bus.m_valid, 0);
    check("mid_level", bus.level, 0);
    bus.m_ready = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.m_valid) n_valid++;
    end
    check("mid_no_stale", n_valid, 0);
    write_word(8'h5A);
    write_word(8'hC3);
    wait_drain("drain_recover", 20);
    check("final_err_und", err_und, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
